// File: rtl/rv_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// rv_hazard_ctrl
//
// Pipeline hazard controller for the 5-stage RV32I core.
//   - Registers the EX-stage operand forwarding selects (computed while the
//     instruction is in ID, presented while it is in EX).
//   - Detects load-use hazards and stalls PC/IF-ID while bubbling ID/EX.
//   - Flushes IF/ID and ID/EX on a taken branch / jump resolved in EX.
//   - Freezes the whole pipeline while data memory is busy.
//   - Keeps its own shadow copy of destination-register state for the
//     instructions downstream of ID, so the datapath stages do not have to
//     export their pipeline registers.
//
// Handshake / hold semantics: there is no valid/ready pair here. The single
// hold contract is: while o_hz_freeze=1, every stage register from ID/EX
// onwards (and this block's shadow state) keeps its value; while
// o_hz_stall_pc / o_hz_stall_ifid are 1, PC and IF/ID keep their value.
// Flush / bubble outputs replace the named register contents with a bubble
// on the next clock edge.
//
// Ports
//   i_hz_clk, i_hz_rstn           clock, asynchronous active-low reset
//   i_hz_id_rs1/rs2 (+_used)      ID source registers and whether read
//   i_hz_id_rf_we/rf_wa/is_load   ID destination-register information
//   i_hz_ex_flush                 branch taken / jump resolved in EX
//   i_hz_dmem_busy                data memory not done, pipeline holds
//   o_hz_ex_rd1_sel/rd2_sel       registered forward select
//                                 (00 regfile, 01 from MEM, 10 from WB)
//   o_hz_stall_pc/stall_ifid      hold PC / IF-ID
//   o_hz_flush_ifid               clear IF/ID
//   o_hz_bubble_idex              load a bubble into ID/EX
//   o_hz_freeze                   hold ID/EX, EX/MEM, MEM/WB
//
// Optional feature (macro RV_HZ_PERF_CNT_EN):
//   o_hz_stall_cnt  32-bit count of load-use stall cycles
//   o_hz_flush_cnt  32-bit count of flush cycles
//   Freeze cycles are never counted; both counters wrap.
// ---------------------------------------------------------------------------
module rv_hazard_ctrl (
  input  logic       i_hz_clk,
  input  logic       i_hz_rstn,
  input  logic [4:0] i_hz_id_rs1,
  input  logic [4:0] i_hz_id_rs2,
  input  logic       i_hz_id_rs1_used,
  input  logic       i_hz_id_rs2_used,
  input  logic       i_hz_id_rf_we,
  input  logic [4:0] i_hz_id_rf_wa,
  input  logic       i_hz_id_is_load,
  input  logic       i_hz_ex_flush,
  input  logic       i_hz_dmem_busy,
  output logic [1:0] o_hz_ex_rd1_sel,
  output logic [1:0] o_hz_ex_rd2_sel,
  output logic       o_hz_stall_pc,
  output logic       o_hz_stall_ifid,
  output logic       o_hz_flush_ifid,
  output logic       o_hz_bubble_idex,
  output logic       o_hz_freeze
`ifdef RV_HZ_PERF_CNT_EN
  ,
  output logic [31:0] o_hz_stall_cnt,
  output logic [31:0] o_hz_flush_cnt
`endif
);

  // Forward select encoding.
  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;

  // Per-cycle action, highest priority first: freeze > flush > lu > normal.
  typedef enum logic [1:0] {
    ACT_NORMAL = 2'd0,
    ACT_LU     = 2'd1,
    ACT_FLUSH  = 2'd2,
    ACT_FREEZE = 2'd3
  } act_e;

  // Shadow slot for the instruction in EX. we=0 means the slot is empty.
  typedef struct packed {
    logic       we;
    logic [4:0] wa;
    logic       is_load;
  } ex_slot_t;

  // Shadow slot for the instruction in MEM. Whether it was a load no longer
  // matters once it has left EX: its data is available by the time a
  // consumer in EX needs it, so only the write information is kept.
  typedef struct packed {
    logic       we;
    logic [4:0] wa;
  } mem_slot_t;

  // The instruction in WB is only relevant to the register file's own
  // write-through path, which lives outside this block. Forwarding from WB
  // is decided one cycle earlier from the MEM slot (it is registered), so no
  // WB shadow storage is observable and none is kept.

  ex_slot_t  ex_slot;
  mem_slot_t mem_slot;
  ex_slot_t  id_slot;

  logic [1:0] rd1_sel_q;
  logic [1:0] rd2_sel_q;
  logic [1:0] rd1_sel_d;
  logic [1:0] rd2_sel_d;

  logic ex_hit1;
  logic ex_hit2;
  logic mem_hit1;
  logic mem_hit2;
  logic load_use;

  act_e act;

  // A producer matches a source only if it really writes a non-x0 register
  // and the consumer really reads that source.
  function automatic logic reg_match(
    input logic       we,
    input logic [4:0] wa,
    input logic [4:0] rs,
    input logic       used
  );
    return we && (wa != 5'd0) && (wa == rs) && used;
  endfunction

  assign id_slot = '{we:      i_hz_id_rf_we,
                     wa:      i_hz_id_rf_wa,
                     is_load: i_hz_id_is_load};

  assign ex_hit1  = reg_match(ex_slot.we,  ex_slot.wa,  i_hz_id_rs1, i_hz_id_rs1_used);
  assign ex_hit2  = reg_match(ex_slot.we,  ex_slot.wa,  i_hz_id_rs2, i_hz_id_rs2_used);
  assign mem_hit1 = reg_match(mem_slot.we, mem_slot.wa, i_hz_id_rs1, i_hz_id_rs1_used);
  assign mem_hit2 = reg_match(mem_slot.we, mem_slot.wa, i_hz_id_rs2, i_hz_id_rs2_used);

  // A load in EX has no data until it reaches WB, so a consumer directly
  // behind it must wait one cycle.
  assign load_use = ex_slot.is_load && (ex_hit1 || ex_hit2);

  // Action decode and hazard outputs (zero latency, purely combinational).
  always_comb begin
    act              = ACT_NORMAL;
    o_hz_freeze      = 1'b0;
    o_hz_stall_pc    = 1'b0;
    o_hz_stall_ifid  = 1'b0;
    o_hz_flush_ifid  = 1'b0;
    o_hz_bubble_idex = 1'b0;

    if (i_hz_dmem_busy) begin
      // A flush arriving now is dropped: the branch sitting in EX is frozen
      // as well and raises the flush again once the freeze lifts.
      act             = ACT_FREEZE;
      o_hz_freeze     = 1'b1;
      o_hz_stall_pc   = 1'b1;
      o_hz_stall_ifid = 1'b1;
    end else if (i_hz_ex_flush) begin
      // The ID instruction is on the wrong path, so a load-use stall for it
      // would be pointless; flush wins and the front end keeps fetching.
      act              = ACT_FLUSH;
      o_hz_flush_ifid  = 1'b1;
      o_hz_bubble_idex = 1'b1;
    end else if (load_use) begin
      act              = ACT_LU;
      o_hz_stall_pc    = 1'b1;
      o_hz_stall_ifid  = 1'b1;
      o_hz_bubble_idex = 1'b1;
    end
  end

  // Next forward selects for the ID instruction. The EX-slot producer is the
  // younger of the two and will be in MEM when the consumer reaches EX, so
  // it takes precedence over the MEM-slot producer (which will be in WB).
  always_comb begin
    rd1_sel_d = SEL_RF;
    rd2_sel_d = SEL_RF;
    if (ex_hit1) begin
      rd1_sel_d = SEL_MEM;
    end else if (mem_hit1) begin
      rd1_sel_d = SEL_WB;
    end
    if (ex_hit2) begin
      rd2_sel_d = SEL_MEM;
    end else if (mem_hit2) begin
      rd2_sel_d = SEL_WB;
    end
  end

  // Shadow pipeline and registered selects.
  always_ff @(posedge i_hz_clk or negedge i_hz_rstn) begin
    if (!i_hz_rstn) begin
      ex_slot   <= '0;
      mem_slot  <= '0;
      rd1_sel_q <= SEL_RF;
      rd2_sel_q <= SEL_RF;
    end else if (act != ACT_FREEZE) begin
      mem_slot <= '{we: ex_slot.we, wa: ex_slot.wa};
      if (act == ACT_NORMAL) begin
        ex_slot   <= id_slot;
        rd1_sel_q <= rd1_sel_d;
        rd2_sel_q <= rd2_sel_d;
      end else begin
        // Flush or load-use: a bubble enters EX and forwards nothing.
        ex_slot   <= '0;
        rd1_sel_q <= SEL_RF;
        rd2_sel_q <= SEL_RF;
      end
    end
  end

  assign o_hz_ex_rd1_sel = rd1_sel_q;
  assign o_hz_ex_rd2_sel = rd2_sel_q;

`ifdef RV_HZ_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge i_hz_clk or negedge i_hz_rstn) begin
    if (!i_hz_rstn) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (act == ACT_LU) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (act == ACT_FLUSH) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign o_hz_stall_cnt = stall_cnt_q;
  assign o_hz_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_rv_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rv_hazard_ctrl
//
// Self-checking bench for rv_hazard_ctrl. Directed scenarios follow the
// pipeline walk-throughs (ALU chain, gap of one, load-use, x0/unused,
// flush vs. load-use, freeze, reset during freeze); a randomized run is
// checked against an instruction-history model of the pipeline.
// Build with RV_HZ_PERF_CNT_EN defined to cover the counters as well.
// ---------------------------------------------------------------------------
module tb_rv_hazard_ctrl;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- DUT signals ----------------
  logic [4:0] rs1, rs2, wa;
  logic       u1, u2, we, ld, flush, busy;
  logic [1:0] sel1, sel2;
  logic       stall_pc, stall_ifid, flush_ifid, bubble, freeze;
`ifdef RV_HZ_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  rv_hazard_ctrl dut (
    .i_hz_clk         (clk),
    .i_hz_rstn        (rst_n),
    .i_hz_id_rs1      (rs1),
    .i_hz_id_rs2      (rs2),
    .i_hz_id_rs1_used (u1),
    .i_hz_id_rs2_used (u2),
    .i_hz_id_rf_we    (we),
    .i_hz_id_rf_wa    (wa),
    .i_hz_id_is_load  (ld),
    .i_hz_ex_flush    (flush),
    .i_hz_dmem_busy   (busy),
    .o_hz_ex_rd1_sel  (sel1),
    .o_hz_ex_rd2_sel  (sel2),
    .o_hz_stall_pc    (stall_pc),
    .o_hz_stall_ifid  (stall_ifid),
    .o_hz_flush_ifid  (flush_ifid),
    .o_hz_bubble_idex (bubble),
    .o_hz_freeze      (freeze)
`ifdef RV_HZ_PERF_CNT_EN
    ,
    .o_hz_stall_cnt   (stall_cnt),
    .o_hz_flush_cnt   (flush_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // hist[0] is the instruction that most recently entered EX, hist[1] the
  // one before it (now in MEM), hist[2] the one before that (now in WB).
  typedef struct packed {
    logic       we;
    logic [4:0] wa;
    logic       ld;
  } instr_t;

  instr_t      hist[$];
  logic [1:0]  m_sel1, m_sel2;
  int unsigned m_stall_cnt, m_flush_cnt;
  logic        e_stall_pc, e_stall_ifid, e_flush_ifid, e_bubble, e_freeze;
  logic        e_lu;

  function automatic logic depends(input instr_t p, input logic [4:0] rs, input logic used);
    return used && p.we && p.wa != 5'd0 && p.wa == rs;
  endfunction

  // Distance (in instructions) back to the newest producer of rs, 0 if none
  // among the two in-flight predecessors. Distance 1 -> from MEM, 2 -> WB.
  function automatic logic [1:0] fwd_dist(input logic [4:0] rs, input logic used);
    for (int k = 0; k < 2; k++) begin
      if (depends(hist[k], rs, used)) return 2'(k + 1);
    end
    return 2'd0;
  endfunction

  task automatic model_reset();
    hist = {instr_t'(0), instr_t'(0), instr_t'(0)};
    m_sel1 = 2'd0;
    m_sel2 = 2'd0;
    m_stall_cnt = 0;
    m_flush_cnt = 0;
  endtask

  task automatic model_eval();
    e_lu = hist[0].ld && (depends(hist[0], rs1, u1) || depends(hist[0], rs2, u2));
    e_freeze     = busy;
    e_flush_ifid = !busy && flush;
    e_stall_pc   = busy || (!flush && e_lu);
    e_stall_ifid = e_stall_pc;
    e_bubble     = !busy && (flush || e_lu);
  endtask

  task automatic model_step();
    instr_t nxt;
    model_eval();
    if (!busy) begin
      if (flush || e_lu) begin
        nxt = '0;
        m_sel1 = 2'd0;
        m_sel2 = 2'd0;
        if (flush) m_flush_cnt++;
        else m_stall_cnt++;
      end else begin
        nxt = '{we: we, wa: wa, ld: ld};
        m_sel1 = fwd_dist(rs1, u1);
        m_sel2 = fwd_dist(rs2, u2);
      end
      hist.push_front(nxt);
      while (hist.size() > 3) void'(hist.pop_back());
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_id(input logic [4:0] a1, input logic [4:0] a2,
                        input logic b1, input logic b2,
                        input logic w, input logic [4:0] d, input logic l);
    rs1 = a1; rs2 = a2; u1 = b1; u2 = b2; we = w; wa = d; ld = l;
    #1;
  endtask

  task automatic nop();
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  // Advance one clock, keeping the model in step with the DUT.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; busy = 1'b0;
    nop();
    #3;
    checks++; if (sel1 !== 2'd0) begin errors++; $display("FAIL reset_rd1_sel got %0d exp 0", sel1); end
    checks++; if (sel2 !== 2'd0) begin errors++; $display("FAIL reset_rd2_sel got %0d exp 0", sel2); end
    checks++; if ({stall_pc, stall_ifid, flush_ifid, bubble, freeze} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 00000", {stall_pc, stall_ifid, flush_ifid, bubble, freeze});
    end
`ifdef RV_HZ_PERF_CNT_EN
    checks++; if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      errors++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", stall_cnt, flush_cnt);
    end
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    #1;
  endtask

  task automatic test_alu_chain();
    set_id(5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0);   // addi x5,x0,..
    tick();
    set_id(5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0);   // add x6,x5,x5
    checks++; if (stall_pc !== 1'b0 || bubble !== 1'b0) begin
      errors++; $display("FAIL alu_no_stall got %b%b exp 00", stall_pc, bubble);
    end
    tick();
    nop();
    checks++; if (sel1 !== 2'b01) begin errors++; $display("FAIL alu_rd1_sel got %0d exp 1", sel1); end
    checks++; if (sel2 !== 2'b01) begin errors++; $display("FAIL alu_rd2_sel got %0d exp 1", sel2); end
    tick();
  endtask

  task automatic test_gap_one();
    set_id(5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0);   // writer x7
    tick();
    set_id(5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 5'd10, 1'b0);  // unrelated
    tick();
    set_id(5'd3, 5'd7, 1'b1, 1'b1, 1'b1, 5'd11, 1'b0);  // reader x7 in rs2
    tick();
    nop();
    checks++; if (sel2 !== 2'b10) begin errors++; $display("FAIL gap_rd2_sel got %0d exp 2", sel2); end
    checks++; if (sel1 !== 2'b00) begin errors++; $display("FAIL gap_rd1_sel got %0d exp 0", sel1); end
    tick();
  endtask

  task automatic test_load_use();
    int unsigned base_stall;
    base_stall = m_stall_cnt;
    set_id(5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b1);   // lw x8
    tick();
    set_id(5'd8, 5'd0, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0);   // add x9,x8,x0
    checks++; if ({stall_pc, stall_ifid, bubble, flush_ifid} !== 4'b1110) begin
      errors++; $display("FAIL lu_stall got %b exp 1110", {stall_pc, stall_ifid, bubble, flush_ifid});
    end
    tick();
    checks++; if ({stall_pc, stall_ifid, bubble} !== 3'b000) begin
      errors++; $display("FAIL lu_one_cycle got %b exp 000", {stall_pc, stall_ifid, bubble});
    end
    tick();
    nop();
    checks++; if (sel1 !== 2'b10) begin errors++; $display("FAIL lu_rd1_sel got %0d exp 2", sel1); end
    checks++; if (sel2 !== 2'b00) begin errors++; $display("FAIL lu_rd2_sel got %0d exp 0", sel2); end
`ifdef RV_HZ_PERF_CNT_EN
    checks++; if (stall_cnt !== 32'(base_stall + 1)) begin
      errors++; $display("FAIL lu_stall_cnt got %0d exp %0d", stall_cnt, base_stall + 1);
    end
`endif
    tick();
  endtask

  task automatic test_x0_unused();
    set_id(5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0);   // writer of x0
    tick();
    set_id(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd12, 1'b0);  // reader of x0
    tick();
    set_id(5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b1);   // lw x3
    checks++; if (sel1 !== 2'b00 || sel2 !== 2'b00) begin
      errors++; $display("FAIL x0_sel got %0d/%0d exp 0/0", sel1, sel2);
    end
    tick();
    set_id(5'd3, 5'd3, 1'b0, 1'b0, 1'b1, 5'd4, 1'b0);   // lui x4 (rs fields = 3)
    checks++; if (stall_pc !== 1'b0 || bubble !== 1'b0) begin
      errors++; $display("FAIL unused_no_stall got %b%b exp 00", stall_pc, bubble);
    end
    tick();
    nop();
    checks++; if (sel1 !== 2'b00 || sel2 !== 2'b00) begin
      errors++; $display("FAIL unused_sel got %0d/%0d exp 0/0", sel1, sel2);
    end
    tick();
  endtask

  task automatic test_flush_beats_lu();
    int unsigned base_stall, base_flush;
    base_stall = m_stall_cnt;
    base_flush = m_flush_cnt;
    set_id(5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b1);   // lw x8
    tick();
    set_id(5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0);   // dependent add
    flush = 1'b1;
    #1;
    checks++; if ({flush_ifid, bubble, stall_pc, stall_ifid} !== 4'b1100) begin
      errors++; $display("FAIL flush_lu got %b exp 1100", {flush_ifid, bubble, stall_pc, stall_ifid});
    end
    tick();
    flush = 1'b0;
    nop();
    checks++; if (sel1 !== 2'b00 || sel2 !== 2'b00) begin
      errors++; $display("FAIL flush_sel got %0d/%0d exp 0/0", sel1, sel2);
    end
`ifdef RV_HZ_PERF_CNT_EN
    checks++; if (flush_cnt !== 32'(base_flush + 1) || stall_cnt !== 32'(base_stall)) begin
      errors++; $display("FAIL flush_cnt got %0d/%0d exp %0d/%0d", flush_cnt, stall_cnt, base_flush + 1, base_stall);
    end
`endif
    tick();
  endtask

  task automatic test_freeze();
    int unsigned base_stall, base_flush;
    set_id(5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0);   // addi x5
    tick();
    set_id(5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0);   // add x6,x5,x5
    tick();
    base_stall = m_stall_cnt;
    base_flush = m_flush_cnt;
    set_id(5'd6, 5'd5, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0);   // add x7,x6,x5
    busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      flush = (i == 1);
      #1;
      checks++; if ({freeze, stall_pc, stall_ifid, flush_ifid, bubble} !== 5'b11100) begin
        errors++; $display("FAIL freeze_ctrl%0d got %b exp 11100", i, {freeze, stall_pc, stall_ifid, flush_ifid, bubble});
      end
      checks++; if (sel1 !== 2'b01 || sel2 !== 2'b01) begin
        errors++; $display("FAIL freeze_hold%0d got %0d/%0d exp 1/1", i, sel1, sel2);
      end
      tick();
    end
    busy = 1'b0;
    flush = 1'b0;
    #1;
    checks++; if ({freeze, stall_pc, bubble} !== 3'b000) begin
      errors++; $display("FAIL freeze_release got %b exp 000", {freeze, stall_pc, bubble});
    end
    tick();
    nop();
    checks++; if (sel1 !== 2'b01 || sel2 !== 2'b10) begin
      errors++; $display("FAIL freeze_resume got %0d/%0d exp 1/2", sel1, sel2);
    end
`ifdef RV_HZ_PERF_CNT_EN
    checks++; if (stall_cnt !== 32'(base_stall) || flush_cnt !== 32'(base_flush)) begin
      errors++; $display("FAIL freeze_cnt got %0d/%0d exp %0d/%0d", stall_cnt, flush_cnt, base_stall, base_flush);
    end
`endif
    tick();
  endtask

  task automatic test_reset_in_freeze();
    set_id(5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b1);   // lw x8
    tick();
    set_id(5'd8, 5'd8, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0);   // dependent
    busy = 1'b1;
    #1;
    tick();
    rst_n = 1'b0;
    busy = 1'b0;
    #1;
    checks++; if ({stall_pc, stall_ifid, flush_ifid, bubble, freeze} !== 5'b0 || sel1 !== 2'd0 || sel2 !== 2'd0) begin
      errors++; $display("FAIL rst_freeze got %b sel %0d/%0d exp 00000 sel 0/0",
                         {stall_pc, stall_ifid, flush_ifid, bubble, freeze}, sel1, sel2);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    #1;
    checks++; if (stall_pc !== 1'b0 || bubble !== 1'b0) begin
      errors++; $display("FAIL rst_no_hazard got %b%b exp 00", stall_pc, bubble);
    end
`ifdef RV_HZ_PERF_CNT_EN
    checks++; if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      errors++; $display("FAIL rst_cnt got %0d/%0d exp 0/0", stall_cnt, flush_cnt);
    end
`endif
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      busy  = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 7) == 0);
      set_id(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
             1'($urandom_range(0, 2) == 0));
      model_eval();
      checks++; if (sel1 !== m_sel1) begin errors++; $display("FAIL rnd_rd1_sel[%0d] got %0d exp %0d", n, sel1, m_sel1); end
      checks++; if (sel2 !== m_sel2) begin errors++; $display("FAIL rnd_rd2_sel[%0d] got %0d exp %0d", n, sel2, m_sel2); end
      checks++; if ({stall_pc, stall_ifid, flush_ifid, bubble, freeze} !==
                    {e_stall_pc, e_stall_ifid, e_flush_ifid, e_bubble, e_freeze}) begin
        errors++; $display("FAIL rnd_ctrl[%0d] got %b exp %b", n,
                           {stall_pc, stall_ifid, flush_ifid, bubble, freeze},
                           {e_stall_pc, e_stall_ifid, e_flush_ifid, e_bubble, e_freeze});
      end
`ifdef RV_HZ_PERF_CNT_EN
      checks++; if (stall_cnt !== 32'(m_stall_cnt) || flush_cnt !== 32'(m_flush_cnt)) begin
        errors++; $display("FAIL rnd_cnt[%0d] got %0d/%0d exp %0d/%0d", n, stall_cnt, flush_cnt, m_stall_cnt, m_flush_cnt);
      end
`endif
      tick();
    end
    busy = 1'b0;
    flush = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_alu_chain();
    test_gap_one();
    test_load_use();
    test_x0_unused();
    test_flush_beats_lu();
    test_freeze();
    test_reset_in_freeze();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
